chacha_stream: RTL and testbench

CHACHA_STREAM -- requirements
Module: chacha_stream

---
 rtl/chacha_pkg.sv | 36 +++
 rtl/chacha_qr.sv | 26 ++
 rtl/chacha_stream.sv | 167 ++++++++++++++++
 tb/tb_chacha_stream.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/chacha_pkg.sv
// rtl/chacha_pkg.sv - shared ChaCha constants, types and helpers
package chacha_pkg;

  localparam int WORD_W  = 32;
  localparam int BLOCK_W = 512;
  localparam int N_WORDS = BLOCK_W / WORD_W;
  localparam int KEY_W   = 256;
  localparam int CTR_W   = 64;

  // "expand 32-byte k" and "expand 16-byte k", word 0 in the low bits
  localparam logic [127:0] SIGMA = {32'h6b206574, 32'h79622d32, 32'h3320646e, 32'h61707865};
  localparam logic [127:0] TAU   = {32'h6b206574, 32'h79622d36, 32'h3120646e, 32'h61707865};

  localparam int ROUNDS_LEGAL_A = 8;
  localparam int ROUNDS_LEGAL_B = 12;
  localparam int ROUNDS_LEGAL_C = 20;

  typedef logic [N_WORDS-1:0][WORD_W-1:0] block_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ROUND,
    ST_FINAL,
    ST_WAIT,
    ST_HALT
  } chacha_state_e;

  function automatic bit rounds_legal(input int r);
    return (r == ROUNDS_LEGAL_A) || (r == ROUNDS_LEGAL_B) || (r == ROUNDS_LEGAL_C);
  endfunction

  function automatic logic [WORD_W-1:0] rotl(input logic [WORD_W-1:0] v, input int n);
    return (v << n) | (v >> (WORD_W - n));
  endfunction

endpackage

// File: rtl/chacha_qr.sv
// rtl/chacha_qr.sv - combinational ChaCha quarter round
module chacha_qr
  import chacha_pkg::*;
(
  input  logic [WORD_W-1:0] a_in,
  input  logic [WORD_W-1:0] b_in,
  input  logic [WORD_W-1:0] c_in,
  input  logic [WORD_W-1:0] d_in,
  output logic [WORD_W-1:0] a_out,
  output logic [WORD_W-1:0] b_out,
  output logic [WORD_W-1:0] c_out,
  output logic [WORD_W-1:0] d_out
);

  logic [WORD_W-1:0] a1, b1, c1, d1;

  assign a1    = a_in + b_in;
  assign d1    = rotl(d_in ^ a1, 16);
  assign c1    = c_in + d1;
  assign b1    = rotl(b_in ^ c1, 12);
  assign a_out = a1 + b1;
  assign d_out = rotl(d1 ^ a_out, 8);
  assign c_out = c1 + d_out;
  assign b_out = rotl(b1 ^ c_out, 7);

endmodule

// File: rtl/chacha_stream.sv
// rtl/chacha_stream.sv - ChaCha stream cipher, one 512-bit block per accept
// One round per cycle; the keystream is buffered ROUNDS+1 cycles after init or accept.
module chacha_stream
  import chacha_pkg::*;
#(
  parameter int ROUNDS       = 20,
  parameter bit HALT_ON_WRAP = 1'b1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               init,
  input  logic [KEY_W-1:0]   key,
  input  logic               keylen,
  input  logic [CTR_W-1:0]   iv,
  input  logic [CTR_W-1:0]   ctr,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [BLOCK_W-1:0] in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BLOCK_W-1:0] out_data,
  output logic               ready,
  output logic               ctr_wrap
);

  if (!rounds_legal(ROUNDS)) begin : g_bad_rounds
    $fatal(1, "chacha_stream: ROUNDS must be 8, 12 or 20");
  end

  localparam int                RIDX_W    = 5;
  localparam logic [RIDX_W-1:0] RIDX_LAST = RIDX_W'(ROUNDS - 1);

  chacha_state_e     state_q;
  block_t            x_q, in_q, ks_q;
  block_t            x_rnd, ks_sum, in_next, init_state;
  logic [RIDX_W-1:0] ridx_q;
  logic [CTR_W-1:0]  ctr_q, ctr_next;
  logic              diag, accept;

  logic [WORD_W-1:0] qa_in  [4];
  logic [WORD_W-1:0] qb_in  [4];
  logic [WORD_W-1:0] qc_in  [4];
  logic [WORD_W-1:0] qd_in  [4];
  logic [WORD_W-1:0] qa_out [4];
  logic [WORD_W-1:0] qb_out [4];
  logic [WORD_W-1:0] qc_out [4];
  logic [WORD_W-1:0] qd_out [4];

  function automatic block_t build_state(
    input logic [KEY_W-1:0] k,
    input logic             klen,
    input logic [CTR_W-1:0] nonce,
    input logic [CTR_W-1:0] blk
  );
    block_t s;
    s[3:0]   = klen ? SIGMA : TAU;
    s[7:4]   = k[127:0];
    s[11:8]  = klen ? k[255:128] : k[127:0];
    s[13:12] = blk;
    s[15:14] = nonce;
    return s;
  endfunction

  assign diag       = ridx_q[0];
  assign init_state = build_state(key, keylen, iv, ctr);
  assign ctr_next   = ctr_q + 64'd1;
  assign in_ready   = (state_q == ST_WAIT) && (!out_valid || out_ready);
  assign accept     = in_valid && in_ready;
  assign ready      = (state_q == ST_IDLE) || (state_q == ST_WAIT) || (state_q == ST_HALT);

  always_comb begin
    in_next          = in_q;
    in_next[13:12]   = ctr_next;
  end

  // Lane g takes column g on even rounds, the diagonal starting at word g on odd rounds
  for (genvar g = 0; g < 4; g++) begin : g_qr
    assign qa_in[g] = x_q[g];
    assign qb_in[g] = diag ? x_q[4 + ((g + 1) % 4)]  : x_q[4 + g];
    assign qc_in[g] = diag ? x_q[8 + ((g + 2) % 4)]  : x_q[8 + g];
    assign qd_in[g] = diag ? x_q[12 + ((g + 3) % 4)] : x_q[12 + g];

    chacha_qr u_qr (
      .a_in  (qa_in[g]),
      .b_in  (qb_in[g]),
      .c_in  (qc_in[g]),
      .d_in  (qd_in[g]),
      .a_out (qa_out[g]),
      .b_out (qb_out[g]),
      .c_out (qc_out[g]),
      .d_out (qd_out[g])
    );

    assign x_rnd[g]      = qa_out[g];
    assign x_rnd[4 + g]  = diag ? qb_out[(g + 3) % 4] : qb_out[g];
    assign x_rnd[8 + g]  = diag ? qc_out[(g + 2) % 4] : qc_out[g];
    assign x_rnd[12 + g] = diag ? qd_out[(g + 1) % 4] : qd_out[g];
  end

  for (genvar w = 0; w < N_WORDS; w++) begin : g_sum
    assign ks_sum[w] = x_q[w] + in_q[w];
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      x_q       <= '0;
      in_q      <= '0;
      ks_q      <= '0;
      ridx_q    <= '0;
      ctr_q     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      ctr_wrap  <= 1'b0;
    end else if (init) begin
      // Any in-flight block or pending beat is dropped in favour of the new key
      state_q   <= ST_ROUND;
      x_q       <= init_state;
      in_q      <= init_state;
      ks_q      <= '0;
      ridx_q    <= '0;
      ctr_q     <= ctr;
      out_valid <= 1'b0;
      ctr_wrap  <= 1'b0;
    end else begin
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      case (state_q)
        ST_ROUND: begin
          x_q    <= x_rnd;
          ridx_q <= ridx_q + 1'b1;
          if (ridx_q == RIDX_LAST) begin
            state_q <= ST_FINAL;
          end
        end
        ST_FINAL: begin
          ks_q    <= ks_sum;
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          if (accept) begin
            out_data  <= in_data ^ ks_q;
            out_valid <= 1'b1;
            ctr_q     <= ctr_next;
            in_q      <= in_next;
            x_q       <= in_next;
            ridx_q    <= '0;
            if (ctr_next == '0) begin
              ctr_wrap <= 1'b1;
              if (HALT_ON_WRAP) begin
                state_q <= ST_HALT;
              end else begin
                state_q <= ST_ROUND;
              end
            end else begin
              state_q <= ST_ROUND;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_chacha_stream.sv
// tb/tb_chacha_stream.sv - directed bench for chacha_stream at ROUNDS 20, 8 and 12
module tb_chacha_stream;

  localparam int N_DUT = 3;
  typedef logic [15:0][31:0] st_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n       [N_DUT];
  logic         init_s      [N_DUT];
  logic [255:0] key_s       [N_DUT];
  logic         keylen_s    [N_DUT];
  logic [63:0]  iv_s        [N_DUT];
  logic [63:0]  ctr_s       [N_DUT];
  logic         in_valid_s  [N_DUT];
  logic         in_ready_s  [N_DUT];
  logic [511:0] in_data_s   [N_DUT];
  logic         out_valid_s [N_DUT];
  logic         out_ready_s [N_DUT];
  logic [511:0] out_data_s  [N_DUT];
  logic         ready_s     [N_DUT];
  logic         ctr_wrap_s  [N_DUT];

  for (genvar g = 0; g < N_DUT; g++) begin : g_dut
    chacha_stream #(
      .ROUNDS       (g == 0 ? 20 : (g == 1 ? 8 : 12)),
      .HALT_ON_WRAP (g != 1)
    ) u_dut (
      .clk       (clk),
      .reset_n   (rst_n[g]),
      .init      (init_s[g]),
      .key       (key_s[g]),
      .keylen    (keylen_s[g]),
      .iv        (iv_s[g]),
      .ctr       (ctr_s[g]),
      .in_valid  (in_valid_s[g]),
      .in_ready  (in_ready_s[g]),
      .in_data   (in_data_s[g]),
      .out_valid (out_valid_s[g]),
      .out_ready (out_ready_s[g]),
      .out_data  (out_data_s[g]),
      .ready     (ready_s[g]),
      .ctr_wrap  (ctr_wrap_s[g])
    );
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rl(input logic [31:0] v, input int n);
    return (v << n) | (v >> (32 - n));
  endfunction

  function automatic st_t qr(input st_t w, input int a, input int b, input int c, input int d);
    logic [3:0] ia, ib, ic, id;
    ia = 4'(a); ib = 4'(b); ic = 4'(c); id = 4'(d);
    w[ia] = w[ia] + w[ib]; w[id] = rl(w[id] ^ w[ia], 16);
    w[ic] = w[ic] + w[id]; w[ib] = rl(w[ib] ^ w[ic], 12);
    w[ia] = w[ia] + w[ib]; w[id] = rl(w[id] ^ w[ia], 8);
    w[ic] = w[ic] + w[id]; w[ib] = rl(w[ib] ^ w[ic], 7);
    return w;
  endfunction

  function automatic logic [511:0] ref_block(input logic [255:0] k, input logic kl,
                                             input logic [63:0] n, input logic [63:0] c,
                                             input int rounds);
    st_t s, w, r;
    s[0]     = 32'h61707865;
    s[1]     = kl ? 32'h3320646e : 32'h3120646e;
    s[2]     = kl ? 32'h79622d32 : 32'h79622d36;
    s[3]     = 32'h6b206574;
    s[7:4]   = k[127:0];
    s[11:8]  = kl ? k[255:128] : k[127:0];
    s[13:12] = c;
    s[15:14] = n;
    w = s;
    for (int dr = 0; dr < rounds / 2; dr++) begin
      w = qr(w, 0, 4, 8, 12);  w = qr(w, 1, 5, 9, 13);
      w = qr(w, 2, 6, 10, 14); w = qr(w, 3, 7, 11, 15);
      w = qr(w, 0, 5, 10, 15); w = qr(w, 1, 6, 11, 12);
      w = qr(w, 2, 7, 8, 13);  w = qr(w, 3, 4, 9, 14);
    end
    for (int i = 0; i < 16; i++) r[i[3:0]] = w[i[3:0]] + s[i[3:0]];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_init(input int d, input logic [255:0] k, input logic kl,
                         input logic [63:0] n, input logic [63:0] c);
    key_s[d] = k; keylen_s[d] = kl; iv_s[d] = n; ctr_s[d] = c;
    init_s[d] = 1'b1;
    tick();
    init_s[d] = 1'b0;
  endtask

  task automatic wait_in_ready(input int d, input string tag, output int cycles);
    cycles = 0;
    while (!in_ready_s[d] && cycles < 200) begin
      tick();
      cycles++;
    end
    chk({tag, "_in_ready"}, in_ready_s[d], 1);
  endtask

  task automatic beat(input int d, input logic [511:0] data);
    in_data_s[d]  = data;
    in_valid_s[d] = 1'b1;
    tick();
    in_valid_s[d] = 1'b0;
  endtask

  task automatic rand_vals(output logic [255:0] k, output logic [63:0] n, output logic [511:0] dat);
    for (int i = 0; i < 8; i++) k[32*i +: 32] = $urandom;
    for (int i = 0; i < 2; i++) n[32*i +: 32] = $urandom;
    for (int i = 0; i < 16; i++) dat[32*i +: 32] = $urandom;
  endtask

  task automatic run_blocks(input int d, input int rounds);
    logic [255:0] k;
    logic [63:0]  n;
    logic [511:0] dat;
    logic         kl;
    int           c;
    rand_vals(k, n, dat);
    kl = (d == 1) ? 1'b0 : 1'b1;
    out_ready_s[d] = 1'b1;
    do_init(d, k, kl, n, 64'd0);
    for (int b = 0; b < 3; b++) begin
      wait_in_ready(d, $sformatf("r%0d_b%0d", rounds, b), c);
      chk($sformatf("r%0d_b%0d_latency", rounds, b), c, rounds + 1);
      for (int i = 0; i < 16; i++) dat[32*i +: 32] = $urandom;
      beat(d, dat);
      chk($sformatf("r%0d_b%0d_data", rounds, b), out_data_s[d],
          dat ^ ref_block(k, kl, n, 64'(b), rounds));
      chk($sformatf("r%0d_b%0d_valid", rounds, b), out_valid_s[d], 1);
    end
  endtask

  initial begin
    int           c;
    int           seen;
    logic [511:0] zero_blk, exp1, d2, d3, dat;
    logic [255:0] k1;
    logic [63:0]  n1, ones;
    zero_blk = '0;
    ones     = '1;
    d2       = {16{32'hA5A5_0F0F}};
    for (int d = 0; d < N_DUT; d++) begin
      rst_n[d] = 1'b0; init_s[d] = 1'b0; key_s[d] = '0; keylen_s[d] = 1'b0;
      iv_s[d] = '0; ctr_s[d] = '0; in_valid_s[d] = 1'b0; in_data_s[d] = '0;
      out_ready_s[d] = 1'b1;
    end
    repeat (3) tick();

    chk("rst_out_valid", out_valid_s[0], 0);
    chk("rst_in_ready", in_ready_s[0], 0);
    chk("rst_ready", ready_s[0], 1);
    chk("rst_ctr_wrap", ctr_wrap_s[0], 0);
    chk("rst_out_data", out_data_s[0], 0);
    for (int d = 0; d < N_DUT; d++) rst_n[d] = 1'b1;
    tick();

    // All-zero 256-bit key, first keystream block
    out_ready_s[0] = 1'b0;
    do_init(0, '0, 1'b1, '0, '0);
    chk("kv_busy", ready_s[0], 0);
    wait_in_ready(0, "kv", c);
    chk("kv_ready_latency", c, 21);
    beat(0, zero_blk);
    exp1 = ref_block('0, 1'b1, '0, '0, 20);
    chk("kv_word0", out_data_s[0][31:0], 32'hade0b876);
    chk("kv_word1", out_data_s[0][63:32], 32'h903df1a0);
    chk("kv_block", out_data_s[0], exp1);
    chk("kv_out_valid", out_valid_s[0], 1);
    chk("kv_ready_low", ready_s[0], 0);

    // Backpressure: second block waits behind an unconsumed output
    c = 0;
    while (!ready_s[0] && c < 200) begin
      tick();
      c++;
    end
    chk("bp_block_latency", c, 21);
    in_data_s[0]  = d2;
    in_valid_s[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_hold_data", out_data_s[0], exp1);
      chk("bp_in_ready", in_ready_s[0], 0);
    end
    out_ready_s[0] = 1'b1;
    tick();
    in_valid_s[0] = 1'b0;
    chk("bp_second_data", out_data_s[0], d2 ^ ref_block('0, 1'b1, '0, 64'd1, 20));
    chk("bp_second_valid", out_valid_s[0], 1);
    tick();
    chk("bp_drained", out_valid_s[0], 0);

    // init and accept together: init wins; the new key starts at the last counter value
    rand_vals(k1, n1, d3);
    wait_in_ready(0, "iw", c);
    key_s[0] = k1; keylen_s[0] = 1'b1; iv_s[0] = n1; ctr_s[0] = ones;
    in_data_s[0] = d3; in_valid_s[0] = 1'b1; init_s[0] = 1'b1;
    tick();
    init_s[0] = 1'b0; in_valid_s[0] = 1'b0;
    chk("iw_no_beat", out_valid_s[0], 0);
    chk("iw_busy", ready_s[0], 0);

    wait_in_ready(0, "wrap", c);
    beat(0, d3);
    chk("wrap_flag", ctr_wrap_s[0], 1);
    chk("wrap_data", out_data_s[0], d3 ^ ref_block(k1, 1'b1, n1, ones, 20));
    chk("wrap_halt_ready", ready_s[0], 1);
    in_valid_s[0] = 1'b1;
    tick();
    chk("wrap_drain", out_valid_s[0], 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("halt_in_ready", in_ready_s[0], 0);
    end
    in_valid_s[0] = 1'b0;
    do_init(0, k1, 1'b0, n1, '0);
    chk("reinit_clears_wrap", ctr_wrap_s[0], 0);

    // Re-init at round index 5, then reset mid-round
    repeat (5) tick();
    do_init(0, k1, 1'b0, n1, 64'd7);
    repeat (3) tick();
    rst_n[0] = 1'b0;
    in_valid_s[0] = 1'b1;
    tick();
    rst_n[0] = 1'b1;
    seen = 0;
    repeat (40) begin
      tick();
      if (out_valid_s[0]) seen++;
    end
    in_valid_s[0] = 1'b0;
    chk("rst_mid_no_valid", seen, 0);
    chk("rst_mid_ready", ready_s[0], 1);
    chk("rst_mid_out_data", out_data_s[0], 0);
    chk("rst_mid_ctr_wrap", ctr_wrap_s[0], 0);
    chk("rst_mid_in_ready", in_ready_s[0], 0);

    run_blocks(1, 8);
    run_blocks(2, 12);

    // Wrap with HALT_ON_WRAP=0 keeps running from counter zero
    rand_vals(k1, n1, d3);
    do_init(1, k1, 1'b0, n1, ones);
    wait_in_ready(1, "nw0", c);
    beat(1, d3);
    chk("nowrap_flag", ctr_wrap_s[1], 1);
    chk("nowrap_busy", ready_s[1], 0);
    chk("nowrap_data0", out_data_s[1], d3 ^ ref_block(k1, 1'b0, n1, ones, 8));
    wait_in_ready(1, "nw1", c);
    chk("nowrap_latency", c, 9);
    dat = ~d3;
    beat(1, dat);
    chk("nowrap_data1", out_data_s[1], dat ^ ref_block(k1, 1'b0, n1, '0, 8));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
